// File: rtl/multi_cycle_data_path.sv
// ============================================================================
// Module   : multi_cycle_data_path
// Brief    : Multi-cycle MIPS-style datapath (PC/IR/MDR/A/B/ALUOut, regfile,
//            ALU) with a memory ready/stall handshake.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module multi_cycle_data_path #(
    parameter int              DATA_W   = 32,
    parameter int              NUM_REGS = 32,
    parameter logic [DATA_W-1:0] RESET_PC = '0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              PCWrite,
    input  logic              PCWriteCond,
    input  logic              IorD,
    input  logic              MemRead,
    input  logic              MemWrite,
    input  logic              IRWrite,
    input  logic              RegDst,
    input  logic              MemtoReg,
    input  logic              RegWrite,
    input  logic              ALUSrcA,
    input  logic [1:0]        ALUSrcB,
    input  logic [1:0]        PCSource,
    input  logic [2:0]        ALU_Control,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_ready,
    output logic [DATA_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              mem_rd,
    output logic              mem_wr,
    output logic              stall,
    output logic [DATA_W-1:0] PC_out,
    output logic [31:0]       inst_out,
    output logic [DATA_W-1:0] ALU_out,
    output logic              zero
);

    localparam int c_RA_W = $clog2(NUM_REGS);

    localparam logic [2:0] c_OP_AND = 3'b000;
    localparam logic [2:0] c_OP_OR  = 3'b001;
    localparam logic [2:0] c_OP_ADD = 3'b010;
    localparam logic [2:0] c_OP_XOR = 3'b011;
    localparam logic [2:0] c_OP_NOR = 3'b100;
    localparam logic [2:0] c_OP_LUI = 3'b101;
    localparam logic [2:0] c_OP_SUB = 3'b110;
    localparam logic [2:0] c_OP_SLT = 3'b111;

    logic [DATA_W-1:0] r_pc;
    logic [31:0]       r_ir;
    logic [DATA_W-1:0] r_mdr;
    logic [DATA_W-1:0] r_a;
    logic [DATA_W-1:0] r_b;
    logic [DATA_W-1:0] r_alu_out;
    logic [DATA_W-1:0] r_regs [NUM_REGS];

    logic [c_RA_W-1:0] w_rs;
    logic [c_RA_W-1:0] w_rt;
    logic [c_RA_W-1:0] w_rd;
    logic [c_RA_W-1:0] w_dst;
    logic [DATA_W-1:0] w_wdata;
    logic [DATA_W-1:0] w_imm;
    logic [DATA_W-1:0] w_jump;
    logic [DATA_W-1:0] w_alu_a;
    logic [DATA_W-1:0] w_alu_b;
    logic [DATA_W-1:0] w_alu_res;
    logic [DATA_W-1:0] w_pc_next;
    logic              w_zero;
    logic              w_pc_en;
    logic              w_stall;

    assign w_rs    = r_ir[21 +: c_RA_W];
    assign w_rt    = r_ir[16 +: c_RA_W];
    assign w_rd    = r_ir[11 +: c_RA_W];
    assign w_dst   = RegDst ? w_rd : w_rt;
    assign w_wdata = MemtoReg ? r_mdr : r_alu_out;
    assign w_imm   = {{(DATA_W-16){r_ir[15]}}, r_ir[15:0]};
    assign w_jump  = {r_pc[DATA_W-1:28], r_ir[25:0], 2'b00};

    // Stall is forced low in reset so a pending access cannot leak through.
    assign w_stall = rst & (MemRead | MemWrite) & ~mem_ready;

    assign w_alu_a = ALUSrcA ? r_a : r_pc;

    always_comb begin
        w_alu_b = r_b;
        case (ALUSrcB)
            2'b00:   w_alu_b = r_b;
            2'b01:   w_alu_b = DATA_W'(4);
            2'b10:   w_alu_b = w_imm;
            default: w_alu_b = w_imm << 2;
        endcase
    end

    always_comb begin
        w_alu_res = '0;
        case (ALU_Control)
            c_OP_AND: w_alu_res = w_alu_a & w_alu_b;
            c_OP_OR:  w_alu_res = w_alu_a | w_alu_b;
            c_OP_ADD: w_alu_res = w_alu_a + w_alu_b;
            c_OP_XOR: w_alu_res = w_alu_a ^ w_alu_b;
            c_OP_NOR: w_alu_res = ~(w_alu_a | w_alu_b);
            c_OP_LUI: w_alu_res = w_alu_b << 16;
            c_OP_SUB: w_alu_res = w_alu_a - w_alu_b;
            c_OP_SLT: w_alu_res = {{(DATA_W-1){1'b0}},
                                   ($signed(w_alu_a) < $signed(w_alu_b))};
            default:  w_alu_res = '0;
        endcase
    end

    assign w_zero = (w_alu_res == '0);

    always_comb begin
        w_pc_next = w_alu_res;
        case (PCSource)
            2'b00:   w_pc_next = w_alu_res;
            2'b01:   w_pc_next = r_alu_out;
            2'b10:   w_pc_next = w_jump;
            default: w_pc_next = w_alu_res;
        endcase
    end

    assign w_pc_en = PCWrite | (PCWriteCond & w_zero);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_pc      <= RESET_PC;
            r_ir      <= '0;
            r_mdr     <= '0;
            r_a       <= '0;
            r_b       <= '0;
            r_alu_out <= '0;
            for (int i = 0; i < NUM_REGS; i++) begin
                r_regs[i] <= '0;
            end
        end else if (!w_stall) begin
            // A/B capture pre-write contents when the same register is written.
            r_a       <= r_regs[w_rs];
            r_b       <= r_regs[w_rt];
            r_alu_out <= w_alu_res;
            if (MemRead) begin
                r_mdr <= mem_rdata;
            end
            if (IRWrite) begin
                r_ir <= mem_rdata[31:0];
            end
            if (w_pc_en) begin
                r_pc <= w_pc_next;
            end
            if (RegWrite && (w_dst != '0)) begin
                r_regs[w_dst] <= w_wdata;
            end
        end
    end

    assign mem_addr  = IorD ? r_alu_out : r_pc;
    assign mem_wdata = r_b;
    assign mem_rd    = MemRead;
    assign mem_wr    = MemWrite;
    assign stall     = w_stall;
    assign PC_out    = r_pc;
    assign inst_out  = r_ir;
    assign ALU_out   = r_alu_out;
    assign zero      = w_zero;

endmodule

`default_nettype wire

// File: tb/tb_multi_cycle_data_path.sv
// ============================================================================
// Module   : tb_multi_cycle_data_path
// Brief    : Self-checking bench: directed sequences plus random controls,
//            compared every cycle against an architectural model.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_multi_cycle_data_path;

    localparam logic [31:0] c_RESET_PC = 32'h0040_0000;

    logic        clk;
    logic        rst;
    logic        PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite;
    logic        RegDst, MemtoReg, RegWrite, ALUSrcA;
    logic [1:0]  ALUSrcB, PCSource;
    logic [2:0]  ALU_Control;
    logic [31:0] mem_rdata;
    logic        mem_ready;
    logic [31:0] mem_addr, mem_wdata, PC_out, ALU_out;
    logic [31:0] inst_out;
    logic        mem_rd, mem_wr, stall, zero;

    multi_cycle_data_path #(
        .DATA_W   (32),
        .NUM_REGS (32),
        .RESET_PC (c_RESET_PC)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .PCWrite     (PCWrite),
        .PCWriteCond (PCWriteCond),
        .IorD        (IorD),
        .MemRead     (MemRead),
        .MemWrite    (MemWrite),
        .IRWrite     (IRWrite),
        .RegDst      (RegDst),
        .MemtoReg    (MemtoReg),
        .RegWrite    (RegWrite),
        .ALUSrcA     (ALUSrcA),
        .ALUSrcB     (ALUSrcB),
        .PCSource    (PCSource),
        .ALU_Control (ALU_Control),
        .mem_rdata   (mem_rdata),
        .mem_ready   (mem_ready),
        .mem_addr    (mem_addr),
        .mem_wdata   (mem_wdata),
        .mem_rd      (mem_rd),
        .mem_wr      (mem_wr),
        .stall       (stall),
        .PC_out      (PC_out),
        .inst_out    (inst_out),
        .ALU_out     (ALU_out),
        .zero        (zero)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int n_chk = 0;
    int n_err = 0;
    bit chk_en = 1'b0;
    bit x_win  = 1'b0;

    // Architectural state of the reference model
    logic [31:0] m_pc, m_ir, m_mdr, m_a, m_b, m_aluout;
    logic [31:0] m_regs [32];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: actual=%h expected=%h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] m_sext();
        return {{16{m_ir[15]}}, m_ir[15:0]};
    endfunction

    function automatic logic [31:0] m_result();
        logic [31:0] a, b;
        a = ALUSrcA ? m_a : m_pc;
        case (ALUSrcB)
            2'd0:    b = m_b;
            2'd1:    b = 32'd4;
            2'd2:    b = m_sext();
            default: b = m_sext() << 2;
        endcase
        case (ALU_Control)
            3'd0:    return a & b;
            3'd1:    return a | b;
            3'd2:    return a + b;
            3'd3:    return a ^ b;
            3'd4:    return ~(a | b);
            3'd5:    return b << 16;
            3'd6:    return a - b;
            default: return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
        endcase
    endfunction

    function automatic logic m_stall();
        return (MemRead | MemWrite) & ~mem_ready;
    endfunction

    task automatic model_reset();
        m_pc = c_RESET_PC;
        m_ir = '0; m_mdr = '0; m_a = '0; m_b = '0; m_aluout = '0;
        for (int i = 0; i < 32; i++) m_regs[i] = '0;
    endtask

    task automatic model_step();
        logic [31:0] res, na, nb, npc;
        logic [4:0]  dst;
        if (m_stall()) return;
        res = m_result();
        na  = m_regs[m_ir[25:21]];
        nb  = m_regs[m_ir[20:16]];
        case (PCSource)
            2'd0:    npc = res;
            2'd1:    npc = m_aluout;
            default: npc = {m_pc[31:28], m_ir[25:0], 2'b00};
        endcase
        if (RegWrite) begin
            dst = RegDst ? m_ir[15:11] : m_ir[20:16];
            if (dst != 5'd0) m_regs[dst] = MemtoReg ? m_mdr : m_aluout;
        end
        if (PCWrite || (PCWriteCond && res == 32'd0)) m_pc = npc;
        if (MemRead) m_mdr = mem_rdata;
        if (IRWrite) m_ir = mem_rdata;
        m_a = na;
        m_b = nb;
        m_aluout = res;
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            chk("pc", PC_out, m_pc);
            chk("ir", inst_out, m_ir);
            chk("mem_wdata", mem_wdata, m_b);
            chk("stall", {31'd0, stall}, {31'd0, m_stall()});
            chk("mem_rd", {31'd0, mem_rd}, {31'd0, MemRead});
            chk("mem_wr", {31'd0, mem_wr}, {31'd0, MemWrite});
            if (!x_win) begin
                chk("alu_out", ALU_out, m_aluout);
                chk("zero", {31'd0, zero}, {31'd0, (m_result() == 32'd0)});
                chk("mem_addr", mem_addr, IorD ? m_aluout : m_pc);
            end
        end
    end

    task automatic idle();
        PCWrite = 0; PCWriteCond = 0; IorD = 0; MemRead = 0; MemWrite = 0;
        IRWrite = 0; RegDst = 0; MemtoReg = 0; RegWrite = 0; ALUSrcA = 0;
        ALUSrcB = 2'd0; PCSource = 2'd0; ALU_Control = 3'd2;
        mem_rdata = '0; mem_ready = 1'b1;
    endtask

    task automatic cycle();
        @(posedge clk);
        model_step();
        #1;
    endtask

    task automatic load_ir(input logic [31:0] word);
        idle();
        MemRead = 1; IRWrite = 1; mem_rdata = word;
        cycle();
    endtask

    task automatic fetch(input logic [31:0] word);
        idle();
        MemRead = 1; IRWrite = 1; ALUSrcB = 2'd1; PCWrite = 1; mem_rdata = word;
        cycle();
    endtask

    // One cycle to latch A/B from the new IR, one to compute into ALUOut.
    task automatic exec_alu(input logic [2:0] op, input logic [1:0] srcb);
        idle();
        cycle();
        ALUSrcA = 1; ALUSrcB = srcb; ALU_Control = op;
        cycle();
    endtask

    task automatic write_reg(input logic regdst, input logic memtoreg);
        idle();
        RegWrite = 1; RegDst = regdst; MemtoReg = memtoreg;
        cycle();
    endtask

    task automatic set_reg(input logic [4:0] idx, input logic [31:0] val);
        load_ir(32'h8C00_0000 | ({27'd0, idx} << 16));
        idle();
        MemRead = 1; IorD = 1; mem_rdata = val;
        cycle();
        write_reg(1'b0, 1'b1);
    endtask

    task automatic chk_reg(input logic [4:0] idx, input logic [31:0] exp);
        load_ir({6'd0, idx, 21'd0});
        exec_alu(3'd2, 2'd0);
        chk($sformatf("reg_r%0d", idx), ALU_out, exp);
    endtask

    initial begin
        idle();
        rst = 1'b0;
        model_reset();
        repeat (3) @(posedge clk);
        #2 rst = 1'b1;
        #1;
        chk("rst_pc", PC_out, 32'h0040_0000);
        chk("rst_alu_out", ALU_out, 32'd0);
        chk("rst_ir", inst_out, 32'd0);
        chk("rst_stall", {31'd0, stall}, 32'd0);
        chk_en = 1'b1;
        chk_reg(5'd1, 32'd0);
        chk_reg(5'd17, 32'd0);
        chk_reg(5'd31, 32'd0);

        // Fetch held off by memory for three cycles
        idle();
        MemRead = 1; IRWrite = 1; ALUSrcB = 2'd1; PCWrite = 1;
        mem_rdata = 32'h0043_0820; mem_ready = 0;
        for (int i = 0; i < 3; i++) begin
            cycle();
            chk("fetch_stall", {31'd0, stall}, 32'd1);
            chk("fetch_pc_frozen", PC_out, 32'h0040_0000);
        end
        mem_ready = 1;
        cycle();
        chk("fetch_ir", inst_out, 32'h0043_0820);
        chk("fetch_pc", PC_out, 32'h0040_0004);

        // add r3,r1,r1 and a discarded write to r0
        set_reg(5'd1, 32'h5555_5555);
        load_ir(32'h0021_1820);
        exec_alu(3'd2, 2'd0);
        chk("add_result", ALU_out, 32'hAAAA_AAAA);
        write_reg(1'b1, 1'b0);
        chk_reg(5'd3, 32'hAAAA_AAAA);
        load_ir(32'h0021_0020);
        exec_alu(3'd2, 2'd0);
        write_reg(1'b1, 1'b0);
        chk_reg(5'd0, 32'd0);

        // slt both ways, nor r0,r0
        set_reg(5'd1, 32'hFFFF_FFFF);
        set_reg(5'd2, 32'd1);
        load_ir(32'h0022_202A);
        exec_alu(3'd7, 2'd0);
        chk("slt_neg_lt_pos", ALU_out, 32'd1);
        write_reg(1'b1, 1'b0);
        chk_reg(5'd4, 32'd1);
        load_ir(32'h0041_202A);
        exec_alu(3'd7, 2'd0);
        chk("slt_pos_lt_neg", ALU_out, 32'd0);
        load_ir(32'h0000_2027);
        exec_alu(3'd4, 2'd0);
        chk("nor_r0", ALU_out, 32'hFFFF_FFFF);

        // Jump with an undefined ALU op in flight
        fetch(32'h0800_0010);
        idle();
        PCWrite = 1; PCSource = 2'd2; ALU_Control = 3'bxxx; x_win = 1'b1;
        cycle();
        chk("jump_pc", PC_out, 32'h0000_0040);
        idle();
        cycle();
        x_win = 1'b0;

        // beq taken: 0x44 - 20 = 0x30
        fetch(32'h1021_FFFB);
        idle();
        ALUSrcB = 2'd3;
        cycle();
        chk("beq_target", ALU_out, 32'h0000_0030);
        idle();
        ALUSrcA = 1; ALU_Control = 3'd6; PCWriteCond = 1; PCSource = 2'd1;
        cycle();
        chk("beq_taken_pc", PC_out, 32'h0000_0030);

        // beq not taken: r1 != r2
        fetch(32'h1022_FFFB);
        idle();
        ALUSrcB = 2'd3;
        cycle();
        idle();
        ALUSrcA = 1; ALU_Control = 3'd6; PCWriteCond = 1; PCSource = 2'd1;
        cycle();
        chk("beq_not_taken_pc", PC_out, 32'h0000_0034);

        // Reset asserted in the middle of a stalled store
        idle();
        MemWrite = 1; IorD = 1; mem_ready = 0;
        cycle();
        chk("pre_rst_stall", {31'd0, stall}, 32'd1);
        #2;
        chk_en = 1'b0;
        rst = 1'b0;
        model_reset();
        #1;
        chk("midrst_pc", PC_out, 32'h0040_0000);
        chk("midrst_alu_out", ALU_out, 32'd0);
        chk("midrst_ir", inst_out, 32'd0);
        chk("midrst_wdata", mem_wdata, 32'd0);
        chk("midrst_stall", {31'd0, stall}, 32'd0);
        chk("midrst_mem_wr", {31'd0, mem_wr}, 32'd1);
        repeat (2) @(posedge clk);
        #1 idle();
        #2 rst = 1'b1;
        #1 chk_en = 1'b1;

        // Random control sequences against the model
        for (int n = 0; n < 3000; n++) begin
            PCWrite     = ($urandom_range(0, 3) == 0);
            PCWriteCond = $urandom_range(0, 1);
            IorD        = $urandom_range(0, 1);
            MemRead     = ($urandom_range(0, 2) == 0);
            MemWrite    = ($urandom_range(0, 3) == 0);
            IRWrite     = $urandom_range(0, 1);
            RegDst      = $urandom_range(0, 1);
            MemtoReg    = $urandom_range(0, 1);
            RegWrite    = $urandom_range(0, 1);
            ALUSrcA     = $urandom_range(0, 1);
            ALUSrcB     = 2'($urandom_range(0, 3));
            PCSource    = 2'($urandom_range(0, 2));
            ALU_Control = 3'($urandom_range(0, 7));
            mem_rdata   = $urandom;
            mem_ready   = ($urandom_range(0, 3) != 0);
            cycle();
        end

        idle();
        @(negedge clk);
        #1;
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/multi_cycle_data_path.md
Name: multi_cycle_data_path

Overview:
- Parametrised multi-cycle successor to the single-cycle Data_path.
- Holds PC, IR, MDR, A, B and ALUOut as internal state, plus the register file and ALU.
- Performs one instruction step per clock, sequenced by an external multi-cycle controller.
- Adds a memory ready/stall handshake, which the single-cycle block does not have, so it can work with slow or shared memory.

Parameters:
- DATA_W, 32: datapath/register width; must be >= 32. The instruction is taken from mem_rdata[31:0].
- NUM_REGS, 32: register-file depth, 16 or 32. The rs/rt/rd fields use their low log2(NUM_REGS) bits.
- RESET_PC, 0: PC value loaded on reset.

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous reset, active-low
- PCWrite  in  1  unconditional PC load
- PCWriteCond  in  1  PC load when zero=1 (beq)
- IorD  in  1  mem_addr select: 0=PC, 1=ALUOut
- MemRead  in  1  memory read request
- MemWrite  in  1  memory write request
- IRWrite  in  1  load IR from mem_rdata
- RegDst  in  1  write-register select: 0=rt, 1=rd
- MemtoReg  in  1  write-data select: 0=ALUOut, 1=MDR
- RegWrite  in  1  register-file write enable
- ALUSrcA  in  1  ALU A input: 0=PC, 1=A
- ALUSrcB  in  2  ALU B input: 00=B, 01=4, 10=sext(imm16), 11=sext(imm16)<<2
- PCSource  in  2  next PC: 00=ALU result, 01=ALUOut, 10=jump target
- ALU_Control  in  3  ALU operation
- mem_rdata  in  DATA_W  memory read data
- mem_ready  in  1  memory access complete this cycle
- mem_addr  out  DATA_W  memory address
- mem_wdata  out  DATA_W  store data (B register)
- mem_rd  out  1  = MemRead
- mem_wr  out  1  = MemWrite
- stall  out  1  access pending, state frozen
- PC_out  out  DATA_W  PC register
- inst_out  out  32  IR
- ALU_out  out  DATA_W  ALUOut register
- zero  out  1  combinational ALU result == 0

Behaviour:
- Reset (rst=0, asynchronous):
  - PC=RESET_PC.
  - IR, MDR, A, B, ALUOut = 0.
  - All registers = 0.
  - stall = 0.
  - Reset overrides any pending stall or write.
- Stall rule: stall = (MemRead|MemWrite) & ~mem_ready, combinational.
  - While stall=1, no state element updates (PC, IR, MDR, A, B, ALUOut, register file).
  - Memory outputs stay stable, since they derive only from held state and held controls.
  - mem_ready with no request pending is ignored.
- Updates at posedge when stall=0:
  - A <= R[rs], B <= R[rt], every cycle.
  - ALUOut <= ALU result, every cycle.
  - MDR <= mem_rdata when MemRead.
  - IR <= mem_rdata[31:0] when IRWrite.
  - PC <= next PC when PCWrite | (PCWriteCond & zero).
  - R[dst] <= wdata when RegWrite and dst != 0.
- Register file: two asynchronous read ports, one synchronous write port.
  - Writes to r0 are discarded; r0 always reads 0.
  - Same-cycle write and read of one register: the read (and A/B latch) returns the old value.
- ALU_Control encoding:
  - 000 AND, 001 OR, 010 ADD, 110 SUB
  - 111 SLT: signed; result 1 or 0, zero-extended to DATA_W.
  - 100 NOR, 011 XOR
  - 101 LUI: B<<16
  - All arithmetic is modulo 2^DATA_W with no overflow trap.
  - ALU_Control=x with PCWrite=1, PCSource=10 must not corrupt PC.
- Immediate and jump target:
  - imm16 = IR[15:0], sign-extended to DATA_W.
  - Jump target = {PC[DATA_W-1:28], IR[25:0], 2'b00}.
- mem_addr = IorD ? ALUOut : PC.

Test Plan:
- Reset with RESET_PC=0x00400000, then release rst -> PC_out=0x00400000, ALU_out=0, stall=0, all register reads 0.
- Fetch with MemRead=1, IRWrite=1, ALUSrcB=01, PCWrite=1, mem_rdata=0x00430820, mem_ready held 0 for 3 cycles then 1 -> stall=1 for 3 cycles with PC frozen; on the ready edge inst_out=0x00430820 and PC=+4.
- R-type ADD sequence r1=0x55555555 (loaded via MDR with MemtoReg=1), then add r3,r1,r1 -> R3=0xAAAAAAAA; a following write to r0 leaves r0=0.
- SLT with r1=0xFFFFFFFF (-1) and r2=1 -> rd=1; swap the operands -> rd=0; NOR of r0,r0 -> 0xFFFFFFFF.
- beq with A==B and imm=-5 -> PC = PC+4-20; with A!=B the PC is unchanged. Jump with IR[25:0]=0x0000010 -> PC={PC[31:28],0x0000040}.
- Assert rst=0 mid-stall (MemWrite=1, mem_ready=0) -> immediate reset values, stall=0 and mem_wr follows the input control only.
